// File: rtl/iot_event_sequencer.sv
// iot_event_sequencer
// Watches per-device on/off status lines and turns every net change into a
// single change/on_off/dev_id pulse. At most one pulse is issued per cycle,
// and devices are serviced in round-robin order. active_count tracks the
// popcount of the state that has already been reported downstream.
module iot_event_sequencer #(
    parameter int N_DEV = 8,
    parameter int ID_W  = $clog2(N_DEV),
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DEV-1:0] dev_status,
    input  logic             hold,
    output logic             change,
    output logic             on_off,
    output logic [ID_W-1:0]  dev_id,
    output logic             pending,
    output logic [CNT_W-1:0] active_count
);

    logic [N_DEV-1:0] sync_meta;
    logic [N_DEV-1:0] sync;
    logic [N_DEV-1:0] reported;
    logic [ID_W-1:0]  ptr;
    logic [N_DEV-1:0] pend;

    logic             sel_found;
    logic [ID_W-1:0]  sel_idx;
    logic [ID_W-1:0]  cand;
    logic [ID_W-1:0]  ptr_next;
    logic             issue;
    logic             issue_val;

    // A device whose synchronized state differs from the last reported state
    // owes an event. Toggling and returning before service cancels itself.
    assign pend = sync ^ reported;

    // Round-robin search: the first set bit of pend at or after ptr, wrapping.
    // NOTE: every signal written in an always_comb gets a default first;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N_DEV; k++) begin
            cand = ID_W'((int'(ptr) + k) % N_DEV);
            if (!sel_found && pend[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Event issue decision and the pointer position just past the winner.
    always_comb begin
        issue     = sel_found && !hold;
        issue_val = sync[sel_idx];
        if (sel_idx == ID_W'(N_DEV - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = sel_idx + ID_W'(1);
        end
    end

    // Two-flop synchronizer for the asynchronous status lines.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= dev_status;
            sync      <= sync_meta;
        end
    end

    // Reported state, round-robin pointer and the outgoing event registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reported     <= '0;
            ptr          <= '0;
            change       <= 1'b0;
            on_off       <= 1'b0;
            dev_id       <= '0;
            active_count <= '0;
        end else if (issue) begin
            change            <= 1'b1;
            on_off            <= issue_val;
            dev_id            <= sel_idx;
            reported[sel_idx] <= issue_val;
            ptr               <= ptr_next;
            if (issue_val) begin
                active_count <= active_count + CNT_W'(1);
            end else begin
                active_count <= active_count - CNT_W'(1);
            end
        end else begin
            change <= 1'b0;
            on_off <= 1'b0;
            dev_id <= '0;
        end
    end

    // Registered "something is still unreported" flag; lags pend by a cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
        end else begin
            pending <= |pend;
        end
    end

endmodule

// File: tb/tb_iot_event_sequencer.sv
// Self-checking bench for iot_event_sequencer (N_DEV = 8).
// Directed table, hand-written hold/reset sequences, and a random soak
// compared cycle by cycle against a behavioural reference model.
module tb_iot_event_sequencer;

    localparam int N = 8;

    logic       clk;
    logic       rst;
    logic [7:0] dev_status;
    logic       hold;
    logic       change;
    logic       on_off;
    logic [2:0] dev_id;
    logic       pending;
    logic [7:0] active_count;

    int checks   = 0;
    int failures = 0;

    iot_event_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .dev_status   (dev_status),
        .hold         (hold),
        .change       (change),
        .on_off       (on_off),
        .dev_id       (dev_id),
        .pending      (pending),
        .active_count (active_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: status history (what sync sees), reported state, pointer.
    logic [7:0] m_h1, m_h2, m_rep;
    int         m_ptr;
    logic       e_change, e_on, e_pending;
    logic [2:0] e_id;
    logic [7:0] e_count;
    logic [7:0] mon;
    bit         model_on = 1'b0;

    typedef struct {
        logic [7:0] ds;
        logic       hold;
        logic       change;
        logic       on_off;
        logic [2:0] id;
        logic       pending;
        logic [7:0] count;
    } vec_t;

    vec_t vec [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_h1  = '0;
        m_h2  = '0;
        m_rep = '0;
        m_ptr = 0;
        mon   = '0;
    endtask

    // One clock edge: predict from the inputs presented, then sample #1 after.
    task automatic tick();
        logic [7:0] sv;
        logic [7:0] pnd;
        sv        = m_h2;
        pnd       = sv ^ m_rep;
        e_change  = 1'b0;
        e_on      = 1'b0;
        e_id      = '0;
        e_pending = (pnd != 0);
        if (!hold && pnd != 0) begin
            for (int k = 0; k < N; k++) begin
                logic [2:0] j;
                j = 3'((m_ptr + k) % N);
                if (pnd[j]) begin
                    e_change = 1'b1;
                    e_on     = sv[j];
                    e_id     = j;
                    m_rep[j] = sv[j];
                    m_ptr    = (int'(j) + 1) % N;
                    break;
                end
            end
        end
        m_h2 = m_h1;
        m_h1 = dev_status;
        e_count = 8'($countones(m_rep));
        @(posedge clk);
        #1;
        if (change === 1'b1) begin
            if (on_off === 1'b1) mon = mon + 8'd1;
            else                 mon = mon - 8'd1;
        end
        if (model_on) begin
            check("model", 32'({change, on_off, dev_id, pending, active_count}),
                  32'({e_change, e_on, e_id, e_pending, e_count}));
        end
    endtask

    initial begin
        int n_ev;
        int got_id;
        int first_at;

        // Directed vectors from the reset state; one row per clock edge.
        vec[0]  = '{8'h08, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'd0};
        vec[1]  = '{8'h08, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'd0};
        vec[2]  = '{8'h08, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 8'd1};
        vec[3]  = '{8'h08, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'd1};
        vec[4]  = '{8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'd1};
        vec[5]  = '{8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'd1};
        vec[6]  = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 8'd0};
        vec[7]  = '{8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'd0};
        vec[8]  = '{8'h07, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'd0};
        vec[9]  = '{8'h07, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'd0};
        vec[10] = '{8'h07, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 8'd1};
        vec[11] = '{8'h07, 1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 8'd2};
        vec[12] = '{8'h07, 1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 8'd3};
        vec[13] = '{8'h07, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'd3};
        vec[14] = '{8'h01, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'd3};
        vec[15] = '{8'h01, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'd3};
        vec[16] = '{8'h01, 1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 8'd2};
        vec[17] = '{8'h01, 1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 8'd1};
        vec[18] = '{8'h01, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'd1};

        // Reset asserted between edges must clear outputs without a clock.
        rst        = 1'b0;
        hold       = 1'b0;
        dev_status = 8'h00;
        model_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_change", 32'(change), 32'd0);
        check("rst_on_off", 32'(on_off), 32'd0);
        check("rst_dev_id", 32'(dev_id), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_count", 32'(active_count), 32'd0);
        #19 rst = 1'b0;

        for (int c = 0; c < 20; c++) begin
            tick();
            check("quiet_after_rst", 32'(change), 32'd0);
        end

        // Table: single device on/off, then simultaneous on and wrapped offs.
        for (int i = 0; i < 19; i++) begin
            dev_status = vec[i].ds;
            hold       = vec[i].hold;
            tick();
            check($sformatf("vec%0d", i),
                  32'({change, on_off, dev_id, pending, active_count}),
                  32'({vec[i].change, vec[i].on_off, vec[i].id, vec[i].pending, vec[i].count}));
        end

        // Hold with a toggle that returns: nothing reported, pending clears.
        hold       = 1'b1;
        dev_status = 8'h21;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("hold_no_event", 32'(change), 32'd0);
        end
        check("hold_pending_set", 32'(pending), 32'd1);
        dev_status = 8'h01;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("hold_no_event", 32'(change), 32'd0);
        end
        hold = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("cancel_no_event", 32'(change), 32'd0);
        end
        check("cancel_pending_clear", 32'(pending), 32'd0);
        check("cancel_count", 32'(active_count), 32'd1);

        // Hold with a net change: exactly one on event for device 5 after release.
        hold       = 1'b1;
        dev_status = 8'h21;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("hold2_no_event", 32'(change), 32'd0);
        end
        hold   = 1'b0;
        n_ev   = 0;
        got_id = -1;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (change === 1'b1) begin
                n_ev++;
                got_id = int'(dev_id);
                check("hold2_on_off", 32'(on_off), 32'd1);
            end
        end
        check("hold2_event_count", 32'(n_ev), 32'd1);
        check("hold2_dev_id", 32'(got_id), 32'd5);
        check("hold2_count", 32'(active_count), 32'd2);

        // Reset in the middle of a burst, then full re-report from index 0.
        dev_status = 8'hFF;
        for (int c = 0; c < 4; c++) tick();
        #3 rst = 1'b1;
        model_reset();
        #1;
        check("midrst_outputs",
              32'({change, on_off, dev_id, pending, active_count}), 32'd0);
        #2 rst = 1'b0;
        n_ev     = 0;
        first_at = -1;
        for (int c = 0; c < 14; c++) begin
            tick();
            if (change === 1'b1) begin
                if (n_ev == 0) first_at = c;
                check("midrst_id", 32'(dev_id), 32'(n_ev));
                check("midrst_on", 32'(on_off), 32'd1);
                n_ev++;
            end
        end
        check("midrst_first_edge", 32'(first_at), 32'd2);
        check("midrst_events", 32'(n_ev), 32'd8);
        check("midrst_count", 32'(active_count), 32'd8);
        check("midrst_monitor", 32'(mon), 32'd8);

        // Random soak against the model, with periodic quiet windows.
        model_on = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 3) == 0) dev_status = dev_status ^ 8'(1 << $urandom_range(0, 7));
            if ($urandom_range(0, 5) == 0) dev_status = dev_status ^ 8'($urandom_range(0, 255));
            hold = ($urandom_range(0, 3) == 0);
            tick();
            if (c % 500 == 499) begin
                hold = 1'b0;
                for (int q = 0; q < 14; q++) tick();
                check("soak_monitor", 32'(mon), 32'(active_count));
                check("soak_popcount", 32'(active_count), 32'($countones(dev_status)));
                check("soak_pending", 32'(pending), 32'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iot_event_sequencer.md
# iot_event_sequencer

Producer side of the active-device counter interface. Watches a vector of per-device on/off status lines, detects which devices have changed state, and serialises those changes into one-per-cycle `change`/`on_off` event pulses for the active-device monitor counter. Arbitration is round-robin. The downstream count always converges to the number of devices currently on.

## Interface

Parameters:
- `N_DEV`, default 8: number of monitored devices. Legal range is 2..255, so the 8-bit downstream counter never wraps.
- `ID_W`, default `$clog2(N_DEV)`: width of `dev_id`.
- `CNT_W`, default 8: width of `active_count`.

Ports:
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `dev_status`, input, `N_DEV`: asynchronous per-device state (1 = on).
- `hold`, input, 1: downstream stall. While 1, no event is issued.
- `change`, output, 1: registered event strobe. Exactly one cycle per event.
- `on_off`, output, 1: event direction (1 = device turned on, 0 = turned off). Valid when `change` = 1; 0 otherwise.
- `dev_id`, output, `ID_W`: index of the device the event refers to. Valid when `change` = 1; 0 otherwise.
- `pending`, output, 1: 1 when any device has an unreported change (registered).
- `active_count`, output, `CNT_W`: popcount of the reported state. Mirrors what the downstream counter must hold.

## Operation

- **Synchronizer:** `dev_status` passes through a 2-flop synchronizer, giving `sync[N_DEV-1:0]`.
- **Reported state:** register `reported[N_DEV-1:0]` holds the last state sent downstream for each device.
- **Pending vector:** `pend = sync ^ reported`. A device that toggles and returns before being serviced produces no event (net-zero). Repeated toggles collapse to the net change.
- **Round-robin pointer:** `ptr` is `ID_W` wide.
- **Selection, each cycle with `hold` = 0 and `pend` ≠ 0:**
  - Select the first set bit of `pend`, searching `ptr`, `ptr+1`, …, `N_DEV-1`, 0, …, `ptr-1`. Call it index `i`.
  - On the next edge: `change` ← 1, `on_off` ← `sync[i]`, `dev_id` ← `i`, `reported[i]` ← `sync[i]`, `ptr` ← (`i`+1) mod `N_DEV`.
- **Otherwise:** `change`, `on_off`, `dev_id` ← 0; `reported` and `ptr` are unchanged.
- **Active count:** `active_count` is incremented when an on event is issued and decremented when an off event is issued. At most one event per cycle, so no saturation is needed (range 0..`N_DEV`).
- **Pending flag:** `pending` ← (`pend` ≠ 0), registered.
- **`hold` behaviour:** `hold` is sampled at the same edge as selection. Pending changes are retained indefinitely, with no loss and no duplication.
- **Simultaneous events:** a device changing in the same cycle it is selected is handled as follows.
  - The emitted value is the `sync` value at the selection edge.
  - Any later difference re-raises `pend[i]` and produces a further event.
- **Invariant:** after `pend` = 0 and all events have been consumed, (count of `on_off`=1 events) − (count of `on_off`=0 events) = `active_count` = popcount(`sync`).
- **Asynchronous reset** (immediately, regardless of `clk`): synchronizer flops, `reported`, `ptr`, `change`, `on_off`, `dev_id`, `pending`, `active_count` all go to 0.
  - Devices that are on when reset releases are reported as on events afterwards, in round-robin order from index 0.

## Timing

- **Input-to-event latency:** a `dev_status` change stable before edge k sets `sync` at edge k+1. With the device selected, `change` is high during the cycle after edge k+2, i.e. 3 edges, given `hold` = 0 and no contention.
- **Contention:** each additional pending device ahead in round-robin order adds 1 cycle.
- **Throughput:** sustained 1 event per cycle while `pend` ≠ 0 and `hold` = 0.
- **`hold` timing:** `hold`=1 sampled at edge k forces `change` = 0 for the cycle after edge k.
- **`pending` lag:** `pending` lags `pend` by 1 cycle. It may read 1 in the cycle after the last event is issued.
- **Reset release:** no event is issued earlier than the 3rd edge after `rst` deasserts.

## Test plan

- **Reset:** assert `rst` asynchronously with `dev_status` = 0 → all outputs 0 immediately. After release, no `change` for 20 cycles.
- **Single device:** `dev_status[3]` 0→1 → one pulse with `change`=1, `on_off`=1, `dev_id`=3 on the 3rd edge; `active_count`=1. Then 1→0 → `change`=1, `on_off`=0, `dev_id`=3; `active_count`=0.
- **Simultaneous and fairness:**
  - `dev_status` = 0x00 → 0x07 in one cycle → three consecutive pulses `dev_id` = 0, 1, 2, all on; `active_count`=3.
  - Then 0x07 → 0x01 → two off events, `dev_id` = 1, 2 (`ptr`=3 at that point, search wraps); `active_count`=1.
- **Hold / cancel:**
  - `hold`=1; `dev_status[5]` 0→1, wait 5 cycles; `dev_status[5]` 1→0; release `hold` → no event, `pending` returns to 0.
  - Repeat with only the 0→1 change → exactly one on event for `dev_id`=5 after release.
- **Random soak:** random `dev_status` toggles and random `hold` for 10k cycles, with a model 8-bit monitor counter fed by `change`/`on_off`. When quiet, the model counter = `active_count` = popcount(`dev_status`). At most one `change` per cycle.
- **Reset mid-operation:** `dev_status` = 0xFF with events in flight; pulse `rst` between edges → outputs 0 at once. After release, 8 on events `dev_id` 0..7 in order; `active_count`=8.
